// File: rtl/dnn_load_pkg.sv
`default_nettype none
// ============================================================================
// Module : dnn_load_pkg
// Brief  : Shared types and defaults for the grouper -> DNN image load path.
// Rev    : 1.0  initial release
// ============================================================================
package dnn_load_pkg;

  localparam int DATA_W_DEF          = 256;
  localparam int WORDS_PER_IMAGE_DEF = 25;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLD    = 2'd1,
    ACK_LOW = 2'd2
  } load_state_t;

endpackage
`default_nettype wire

// File: rtl/image_load_ctrl_rise_detect.sv
`default_nettype none
// ============================================================================
// Module : rise_detect
// Brief  : Registered rising-edge detector, asynchronous active-low reset.
// Rev    : 1.0  initial release
// ============================================================================
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= d;
    end
  end

  assign rise = d & ~r_q;

endmodule
`default_nettype wire

// File: rtl/image_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module : image_load_ctrl
// Brief  : Captures grouper words and offers them to the DNN over a 4-phase
//          handshake. Optional IMAGE_LOAD_CTRL_OVR_CNT_EN adds ovr_cnt.
// Rev    : 1.0  initial release
// ============================================================================
module image_load_ctrl
  import dnn_load_pkg::*;
#(
  parameter int DATA_W          = DATA_W_DEF,
  parameter int WORDS_PER_IMAGE = WORDS_PER_IMAGE_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grp_ready,
  input  logic [DATA_W-1:0] grp_data,
  input  logic              enable,
  input  logic              dnn_ack,
  input  logic              ovr_clr,
`ifdef IMAGE_LOAD_CTRL_OVR_CNT_EN
  output logic [7:0]        ovr_cnt,
`endif
  output logic              group_ready,
  output logic [DATA_W-1:0] group_data,
  output logic [4:0]        word_idx,
  output logic              image_done,
  output logic              overrun,
  output logic              busy
);

  localparam logic [4:0] c_LAST_IDX = 5'(WORDS_PER_IMAGE - 1);

  generate
    if (WORDS_PER_IMAGE < 1 || WORDS_PER_IMAGE > 32) begin : g_words_check
      $error("image_load_ctrl: WORDS_PER_IMAGE must be in 1..32");
    end
  endgenerate

  load_state_t       r_state,       w_state_nxt;
  logic              r_group_ready, w_group_ready_nxt;
  logic [DATA_W-1:0] r_group_data,  w_group_data_nxt;
  logic [4:0]        r_word_idx,    w_word_idx_nxt;
  logic              r_image_done,  w_image_done_nxt;
  logic              r_overrun,     w_overrun_nxt;
  logic              w_new_word;
  logic              w_accept;
  logic              w_drop;

  rise_detect u_rise_detect (
    .clk   (clk),
    .rst_n (rst),
    .d     (grp_ready),
    .rise  (w_new_word)
  );

  assign w_accept = w_new_word & enable;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_group_ready <= 1'b0;
      r_group_data  <= '0;
      r_word_idx    <= 5'd0;
      r_image_done  <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_group_ready <= w_group_ready_nxt;
      r_group_data  <= w_group_data_nxt;
      r_word_idx    <= w_word_idx_nxt;
      r_image_done  <= w_image_done_nxt;
      r_overrun     <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_group_ready_nxt = r_group_ready;
    w_group_data_nxt  = r_group_data;
    w_word_idx_nxt    = r_word_idx;
    w_image_done_nxt  = 1'b0;
    w_drop            = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_group_data_nxt  = grp_data;
          w_group_ready_nxt = 1'b1;
          w_state_nxt       = HOLD;
        end
      end

      HOLD: begin
        w_drop = w_new_word;
        if (dnn_ack) begin
          w_group_ready_nxt = 1'b0;
          w_state_nxt       = ACK_LOW;
        end
      end

      ACK_LOW: begin
        if (dnn_ack) begin
          w_drop = w_new_word;
        end else begin
          if (r_word_idx == c_LAST_IDX) begin
            w_word_idx_nxt   = 5'd0;
            w_image_done_nxt = 1'b1;
          end else begin
            w_word_idx_nxt = r_word_idx + 5'd1;
          end
          // A word arriving as the handshake closes is taken immediately
          if (w_accept) begin
            w_group_data_nxt  = grp_data;
            w_group_ready_nxt = 1'b1;
            w_state_nxt       = HOLD;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end

      default: begin
        w_state_nxt       = IDLE;
        w_group_ready_nxt = 1'b0;
      end
    endcase

    w_overrun_nxt = w_drop | (r_overrun & ~ovr_clr);
  end

`ifdef IMAGE_LOAD_CTRL_OVR_CNT_EN
  logic [7:0] r_ovr_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovr_cnt <= 8'd0;
    end else if (ovr_clr) begin
      r_ovr_cnt <= {7'd0, w_drop};
    end else if (w_drop && (r_ovr_cnt != 8'hFF)) begin
      r_ovr_cnt <= r_ovr_cnt + 8'd1;
    end
  end

  assign ovr_cnt = r_ovr_cnt;
`endif

  assign group_ready = r_group_ready;
  assign group_data  = r_group_data;
  assign word_idx    = r_word_idx;
  assign image_done  = r_image_done;
  assign overrun     = r_overrun;
  assign busy        = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_image_load_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_image_load_ctrl
// Brief  : Self-checking bench for image_load_ctrl with a word-count model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_image_load_ctrl;

  localparam int W = 25;

  logic         clk;
  logic         rst;
  logic         grp_ready;
  logic [255:0] grp_data;
  logic         enable;
  logic         dnn_ack;
  logic         ovr_clr;
  logic         group_ready;
  logic [255:0] group_data;
  logic [4:0]   word_idx;
  logic         image_done;
  logic         overrun;
  logic         busy;
`ifdef IMAGE_LOAD_CTRL_OVR_CNT_EN
  logic [7:0]   ovr_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;
  int m_acked = 0;

  image_load_ctrl #(
    .DATA_W          (256),
    .WORDS_PER_IMAGE (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .grp_ready   (grp_ready),
    .grp_data    (grp_data),
    .enable      (enable),
    .dnn_ack     (dnn_ack),
    .ovr_clr     (ovr_clr),
`ifdef IMAGE_LOAD_CTRL_OVR_CNT_EN
    .ovr_cnt     (ovr_cnt),
`endif
    .group_ready (group_ready),
    .group_data  (group_data),
    .word_idx    (word_idx),
    .image_done  (image_done),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (image_done === 1'b1) n_done++;
  end

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] rnd_word();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at a falling edge: drive inputs, advance across one rising edge.
  task automatic step(input logic gr, input logic [255:0] gd, input logic ak, input logic oc);
    grp_ready = gr;
    grp_data  = gd;
    dnn_ack   = ak;
    ovr_clr   = oc;
    @(negedge clk);
  endtask

  // One full word transfer with random hold/ack durations, checked against the model.
  task automatic do_word(input logic [255:0] w);
    step(1'b1, w, 1'b0, 1'b0);
    chk_b("wd_ready", group_ready, 1'b1);
    chk_w("wd_data", group_data, w);
    chk_i("wd_idx", int'(word_idx), m_acked % W);
    repeat ($urandom_range(0, 2)) step(1'b0, '0, 1'b0, 1'b0);
    chk_b("wd_hold", group_ready, 1'b1);
    repeat ($urandom_range(1, 2)) step(1'b0, '0, 1'b1, 1'b0);
    chk_b("wd_ackhi_ready", group_ready, 1'b0);
    chk_w("wd_ackhi_data", group_data, w);
    step(1'b0, '0, 1'b0, 1'b0);
    m_acked++;
    chk_i("wd_idx_after", int'(word_idx), m_acked % W);
    chk_b("wd_done", image_done, (m_acked % W) == 0);
    chk_b("wd_busy", busy, 1'b0);
  endtask

  initial begin
    logic [255:0] w0;
    logic [255:0] w1;

    rst       = 1'b0;
    grp_ready = 1'b0;
    grp_data  = '0;
    enable    = 1'b1;
    dnn_ack   = 1'b0;
    ovr_clr   = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk_b("rst_ready", group_ready, 1'b0);
    chk_w("rst_data", group_data, 256'd0);
    chk_i("rst_idx", int'(word_idx), 0);
    chk_b("rst_done", image_done, 1'b0);
    chk_b("rst_ovr", overrun, 1'b0);
    chk_b("rst_busy", busy, 1'b0);
    rst = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);

    // Single A5 word
    w0 = {32{8'hA5}};
    step(1'b1, w0, 1'b0, 1'b0);
    chk_b("single_ready", group_ready, 1'b1);
    chk_w("single_data", group_data, w0);
    chk_b("single_busy", busy, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk_b("single_ackhi", group_ready, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    m_acked++;
    chk_i("single_idx", int'(word_idx), 1);
    chk_b("single_idle", busy, 1'b0);

    // Overrun while holding, clear, and set-wins-over-clear
    w0 = rnd_word();
    w1 = rnd_word();
    step(1'b1, w0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b1, w1, 1'b0, 1'b0);
    chk_b("ovr_set", overrun, 1'b1);
    chk_w("ovr_data_kept", group_data, w0);
`ifdef IMAGE_LOAD_CTRL_OVR_CNT_EN
    chk_i("ovr_cnt_1", int'(ovr_cnt), 1);
`endif
    step(1'b0, '0, 1'b0, 1'b1);
    chk_b("ovr_clr", overrun, 1'b0);
`ifdef IMAGE_LOAD_CTRL_OVR_CNT_EN
    chk_i("ovr_cnt_clr", int'(ovr_cnt), 0);
`endif
    step(1'b1, w1, 1'b0, 1'b1);
    chk_b("ovr_set_wins", overrun, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk_b("ovr_clr2", overrun, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, w1, 1'b1, 1'b0);
    chk_b("ovr_acklow_drop", overrun, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    m_acked++;
    chk_i("ovr_idx", int'(word_idx), 2);
    chk_w("ovr_data_final", group_data, w0);
    chk_b("ovr_clr3", overrun, 1'b0);

    // New word arriving as ack falls
    w0 = rnd_word();
    w1 = rnd_word();
    step(1'b1, w0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b1, w1, 1'b0, 1'b0);
    m_acked++;
    chk_i("simul_idx", int'(word_idx), 3);
    chk_b("simul_ready", group_ready, 1'b1);
    chk_w("simul_data", group_data, w1);
    chk_b("simul_ovr", overrun, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    m_acked++;
    chk_i("simul_idx2", int'(word_idx), 4);

    // Random traffic through the end of the first image
    while (m_acked % W != 0) begin
      repeat ($urandom_range(0, 2)) begin
        if ($urandom_range(0, 3) == 0) begin
          enable = 1'b0;
          step(1'b1, rnd_word(), 1'b0, 1'b0);
          chk_b("gate_ready", group_ready, 1'b0);
          chk_b("gate_ovr", overrun, 1'b0);
          step(1'b0, '0, 1'b0, 1'b0);
          enable = 1'b1;
        end else begin
          step(1'b0, '0, 1'b0, 1'b0);
        end
      end
      do_word(rnd_word());
    end
    step(1'b0, '0, 1'b0, 1'b0);
    chk_b("img_done_pulse", image_done, 1'b0);
    chk_i("img_done_count", n_done, 1);
    chk_i("img_idx_wrap", int'(word_idx), 0);
    chk_b("img_busy", busy, 1'b0);

    // Reset in the middle of an image, while holding word 7
    while (m_acked % W != 7) do_word(rnd_word());
    w0 = rnd_word();
    step(1'b1, w0, 1'b0, 1'b0);
    chk_i("mid_idx7", int'(word_idx), 7);
    chk_b("mid_hold", group_ready, 1'b1);
    #2;
    rst       = 1'b0;
    grp_ready = 1'b0;
    #1;
    chk_b("mid_rst_ready", group_ready, 1'b0);
    chk_w("mid_rst_data", group_data, 256'd0);
    chk_i("mid_rst_idx", int'(word_idx), 0);
    chk_b("mid_rst_busy", busy, 1'b0);
    chk_b("mid_rst_ovr", overrun, 1'b0);
    repeat (2) @(negedge clk);
    rst     = 1'b1;
    m_acked = 0;
    step(1'b0, '0, 1'b0, 1'b0);

    // Enable low: three edges ignored
    enable = 1'b0;
    repeat (3) begin
      step(1'b1, rnd_word(), 1'b0, 1'b0);
      chk_b("en_ready", group_ready, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0);
    end
    chk_b("en_ovr", overrun, 1'b0);
    chk_i("en_idx", int'(word_idx), 0);
    enable = 1'b1;

    do_word(rnd_word());
    chk_i("post_rst_idx", int'(word_idx), 1);
    chk_i("final_done_count", n_done, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
